// File: rtl/fns_enc_12_pkg.sv
// fns_enc_12_pkg: Fibonacci weights, limits and FSM encoding shared by the FNS encoder.
package fns_enc_12_pkg;
   localparam int FNSLEN = 12;
   localparam int FNSMAX = 376;
   localparam int FBLEN12 = 9;
   typedef enum logic [1:0] {
      FNS_ENC_IDLE = 2'd0,
      FNS_ENC_CONV = 2'd1,
      FNS_ENC_DONE = 2'd2
   } fns_enc_state_e;
   function automatic logic [8:0] fns_w(input logic [3:0] k);
      case (k)
         4'd0:    fns_w = 9'd1;
         4'd1:    fns_w = 9'd2;
         4'd2:    fns_w = 9'd3;
         4'd3:    fns_w = 9'd5;
         4'd4:    fns_w = 9'd8;
         4'd5:    fns_w = 9'd13;
         4'd6:    fns_w = 9'd21;
         4'd7:    fns_w = 9'd34;
         4'd8:    fns_w = 9'd55;
         4'd9:    fns_w = 9'd89;
         4'd10:   fns_w = 9'd144;
         4'd11:   fns_w = 9'd233;
         default: fns_w = 9'd0;
      endcase
   endfunction
   function automatic logic no_adj(input logic [FNSLEN-1:0] c);
      return ~|(c & (c >> 1));
   endfunction
endpackage

// File: rtl/fns_enc_12_if.sv
// fns_enc_12_if: valid/ready input and output channels of the FNS encoder.
interface fns_enc_12_if #(parameter int FBLEN = 9);
   import fns_enc_12_pkg::*;
   logic in_valid, in_ready, out_valid, out_ready, err;
   logic [FBLEN-1:0] datain;
   logic [FNSLEN-1:0] codeout;
   modport master (output in_valid, datain, out_ready, input in_ready, out_valid, codeout, err);
   modport slave (input in_valid, datain, out_ready, output in_ready, out_valid, codeout, err);
endinterface

// File: rtl/fns_enc_step.sv
// fns_enc_step: one greedy Zeckendorf digit; take the weight whenever the remainder covers it.
module fns_enc_step #(parameter int W = 9) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] weight,
   output logic         dbit,
   output logic [W-1:0] rem_nxt
);
   assign dbit = rem >= weight;
   assign rem_nxt = dbit ? rem - weight : rem;
endmodule

// File: rtl/fns_enc_12.sv
// fns_enc_12: iterative binary to 12-bit Zeckendorf encoder, STEPS digits resolved per clock MSB-first.
module fns_enc_12 import fns_enc_12_pkg::*; #(
   parameter int STEPS = 1,
   parameter int FBLEN = FBLEN12
) (
   input logic clk,
   input logic rst,
   fns_enc_12_if.slave bus
);
   fns_enc_state_e state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [FBLEN-1:0] rem_q, rem_d;
   logic [FNSLEN-1:0] code_q, code_d;
   logic err_q, err_d;
   logic [STEPS:0][FBLEN-1:0] r;
   logic [STEPS-1:0] b;
   logic [STEPS-1:0][3:0] k;
   assign r[0] = rem_q;
   // Chain of greedy stages; stage g resolves digit idx-g.
   for (genvar g = 0; g < STEPS; g++) begin : g_step
      assign k[g] = idx_q - 4'(g);
      fns_enc_step #(.W(FBLEN)) u_step (
         .rem(r[g]),
         .weight(FBLEN'(fns_w(k[g]))),
         .dbit(b[g]),
         .rem_nxt(r[g+1])
      );
   end
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      rem_d = rem_q;
      code_d = code_q;
      err_d = err_q;
      case (state_q)
         FNS_ENC_IDLE: if (bus.in_valid) begin
            rem_d = bus.datain;
            code_d = '0;
            err_d = bus.datain > FBLEN'(FNSMAX);
            idx_d = 4'(FNSLEN-1);
            state_d = err_d ? FNS_ENC_DONE : FNS_ENC_CONV;
         end
         FNS_ENC_CONV: begin
            rem_d = r[STEPS];
            for (int s = 0; s < STEPS; s++) code_d[k[s]] = b[s];
            idx_d = idx_q == 4'(STEPS-1) ? 4'(FNSLEN-1) : idx_q - 4'(STEPS);
            state_d = idx_q == 4'(STEPS-1) ? FNS_ENC_DONE : FNS_ENC_CONV;
         end
         FNS_ENC_DONE: if (bus.out_ready) state_d = FNS_ENC_IDLE;
         default: state_d = FNS_ENC_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FNS_ENC_IDLE;
         idx_q <= 4'(FNSLEN-1);
         rem_q <= '0;
         code_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         rem_q <= rem_d;
         code_q <= code_d;
         err_q <= err_d;
      end
   end
   assign bus.in_ready = state_q == FNS_ENC_IDLE;
   assign bus.out_valid = state_q == FNS_ENC_DONE;
   assign bus.codeout = code_q;
   assign bus.err = err_q;
   a_no_adj: assert property (@(posedge clk) disable iff (rst) state_q == FNS_ENC_DONE |-> no_adj(code_q));
   a_rem_zero: assert property (@(posedge clk) disable iff (rst) state_q == FNS_ENC_DONE && !err_q |-> rem_q == '0);
   a_hold: assert property (@(posedge clk) disable iff (rst)
      state_q == FNS_ENC_DONE && !bus.out_ready |=> $stable(code_q) && $stable(err_q));
endmodule

// File: tb/tb_fns_enc_12.sv
// tb_fns_enc_12: scoreboard bench driving STEPS=1,3,12 encoders in lockstep, checked by decode.
module tb_fns_enc_12;
   typedef struct packed {
      logic [8:0] d;
      logic [11:0] c;
      logic chk;
   } exp_t;
   localparam int W [12] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, out_ready = 1'b1;
   logic [8:0] datain = '0;
   int n_chk = 0, n_fail = 0, lat = 0, n = 0;
   exp_t q1[$], q3[$], q12[$];
   fns_enc_12_if #(.FBLEN(9)) b1 ();
   fns_enc_12_if #(.FBLEN(9)) b3 ();
   fns_enc_12_if #(.FBLEN(9)) b12 ();
   assign b1.in_valid = in_valid;
   assign b3.in_valid = in_valid;
   assign b12.in_valid = in_valid;
   assign b1.datain = datain;
   assign b3.datain = datain;
   assign b12.datain = datain;
   assign b1.out_ready = out_ready;
   assign b3.out_ready = out_ready;
   assign b12.out_ready = out_ready;
   fns_enc_12 #(.STEPS(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
   fns_enc_12 #(.STEPS(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
   fns_enc_12 #(.STEPS(12)) u12 (.clk(clk), .rst(rst), .bus(b12));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic int decode(input logic [11:0] c);
      int s = 0;
      for (int i = 0; i < 12; i++) if (c[i]) s += W[i];
      return s;
   endfunction
   task automatic score(input string tag, input exp_t e, input logic [11:0] c, input logic er);
      logic xe;
      xe = e.d > 9'd376;
      check({tag, "_err"}, 32'(er), 32'(xe));
      if (xe) check({tag, "_zero"}, 32'(c), 0);
      else begin
         check({tag, "_dec"}, decode(c), 32'(e.d));
         check({tag, "_adj"}, 32'(|(c & (c >> 1))), 0);
         if (e.chk) check({tag, "_code"}, 32'(c), 32'(e.c));
      end
   endtask
   always @(negedge clk) if (b1.out_valid && out_ready) begin
      if (q1.size() == 0) check("s1_extra", 1, 0); else score("s1", q1.pop_front(), b1.codeout, b1.err);
   end
   always @(negedge clk) if (b3.out_valid && out_ready) begin
      if (q3.size() == 0) check("s3_extra", 1, 0); else score("s3", q3.pop_front(), b3.codeout, b3.err);
   end
   always @(negedge clk) if (b12.out_valid && out_ready) begin
      if (q12.size() == 0) check("s12_extra", 1, 0); else score("s12", q12.pop_front(), b12.codeout, b12.err);
   end
   task automatic send(input logic [8:0] v, input logic [11:0] c, input logic chk, input bit wt, output int l);
      int m = 0;
      exp_t e;
      while (!(b1.in_ready && b3.in_ready && b12.in_ready) && m < 100) begin
         @(negedge clk);
         m++;
      end
      if (m >= 100) check("in_ready_timeout", 0, 1);
      e = '{d: v, c: c, chk: chk};
      q1.push_back(e);
      q3.push_back(e);
      q12.push_back(e);
      in_valid = 1'b1;
      datain = v;
      @(posedge clk);
      #1 in_valid = 1'b0;
      l = 0;
      if (wt) begin
         m = 0;
         while ((q1.size() != 0 || q3.size() != 0 || q12.size() != 0) && m < 100) begin
            @(negedge clk);
            m++;
            if (l == 0 && b1.out_valid) l = m;
         end
         if (m >= 100) check("done_timeout", 0, 1);
      end
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(b1.out_valid), 0);
      check("rst_codeout", 32'(b1.codeout), 0);
      check("rst_err", 32'(b1.err), 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(b1.in_ready), 1);
      send(9'd0, 12'h000, 1'b1, 1'b1, lat);
      check("lat_zero", lat, 13);
      send(9'd376, 12'hAAA, 1'b1, 1'b1, lat);
      send(9'd1, 12'h001, 1'b1, 1'b1, lat);
      send(9'd4, 12'h005, 1'b1, 1'b1, lat);
      send(9'd377, 12'h000, 1'b1, 1'b1, lat);
      check("lat_err377", lat, 1);
      send(9'd511, 12'h000, 1'b1, 1'b1, lat);
      check("lat_err511", lat, 1);
      out_ready = 1'b0;
      send(9'd100, 12'h214, 1'b1, 1'b0, lat);
      n = 0;
      while (!b1.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("bp_timeout", 0, 1);
      in_valid = 1'b1;
      datain = 9'd5;
      repeat (20) begin
         @(negedge clk);
         check("bp_code", 32'(b1.codeout), 32'h214);
         check("bp_err", 32'(b1.err), 0);
         check("bp_in_ready", 32'(b1.in_ready), 0);
         check("bp_out_valid", 32'(b1.out_valid), 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("bp_idle", 32'(b1.in_ready), 1);
      check("bp_queue", 32'(q1.size() + q3.size() + q12.size()), 0);
      send(9'd200, 12'h000, 1'b0, 1'b0, lat);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(b1.out_valid), 0);
      check("mid_rst_codeout", 32'(b1.codeout), 0);
      q1.delete();
      q3.delete();
      q12.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(9'd4, 12'h005, 1'b1, 1'b1, lat);
      check("lat_after_rst", lat, 13);
      for (int v = 0; v <= 376; v++) begin
         send(9'(v), 12'h000, 1'b0, 1'b1, lat);
         check("lat_sweep", lat, 13);
      end
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
